hilo_muldiv_unit: RTL and testbench

- Execute-stage consumer of the decoded mul/div/HI-LO control bits: mult, multu, div, divu, mthi, mtlo.
- Owns the architectural HI and LO registers.
- Runs a fixed-latency multiply and an iterative 32-step restoring divide.
- Asserts busy so the pipeline stalls mfhi/mflo and further mul/div ops until results land.

---
 rtl/hilo_muldiv_unit_if.sv | 31 +++
 rtl/hilo_muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO mul/div unit.
// The master side issues decoded ops with operands; the slave side reports
// occupancy, completion and the current HI/LO contents.
interface hilo_muldiv_unit_if;
    logic        op_valid;
    logic        op_mult;
    logic        op_multu;
    logic        op_div;
    logic        op_divu;
    logic        op_mthi;
    logic        op_mtlo;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;

    modport master (
        output op_valid, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo,
        output src1, src2, cancel,
        input  busy, done, hi_rdata, lo_rdata
    );

    modport slave (
        input  op_valid, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo,
        input  src1, src2, cancel,
        output busy, done, hi_rdata, lo_rdata
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the execute stage.
// Owns HI and LO, runs a MUL_LAT-edge multiply and a 32-step restoring divide
// followed by one sign-fixup edge. busy stalls upstream while an op is in flight.
// Optional macro HILO_BYPASS_EN: an mthi/mtlo being accepted shows src1 on the
// matching read port combinationally in the same cycle.
module hilo_muldiv_unit #(
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    hilo_muldiv_unit_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic [63:0] prod_q;
    logic [31:0] div_rem;
    logic [31:0] div_quot;
    logic [31:0] div_dsor;
    logic        q_neg;
    logic        r_neg;

    logic        accept;
    logic        sel_mthi;
    logic        sel_mtlo;
    logic        sel_mult;
    logic        sel_multu;
    logic        sel_div;
    logic        sel_divu;

    // Only one op wins: mthi > mtlo > mult > multu > div > divu.
    assign accept    = bus.op_valid && (state == ST_IDLE) && !bus.cancel;
    assign sel_mthi  = accept && bus.op_mthi;
    assign sel_mtlo  = accept && !bus.op_mthi && bus.op_mtlo;
    assign sel_mult  = accept && !bus.op_mthi && !bus.op_mtlo && bus.op_mult;
    assign sel_multu = accept && !bus.op_mthi && !bus.op_mtlo && !bus.op_mult && bus.op_multu;
    assign sel_div   = accept && !bus.op_mthi && !bus.op_mtlo && !bus.op_mult && !bus.op_multu
                       && bus.op_div;
    assign sel_divu  = accept && !bus.op_mthi && !bus.op_mtlo && !bus.op_mult && !bus.op_multu
                       && !bus.op_div && bus.op_divu;

    // The low 64 bits of a 64x64 product are the same for signed and unsigned
    // operands, so sign-extending to 64 bits gives both flavours.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;
    assign mul_a    = {{32{sel_mult & bus.src1[31]}}, bus.src1};
    assign mul_b    = {{32{sel_mult & bus.src2[31]}}, bus.src2};
    assign mul_prod = mul_a * mul_b;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    assign abs_a = (sel_div && bus.src1[31]) ? (32'd0 - bus.src1) : bus.src1;
    assign abs_b = (sel_div && bus.src2[31]) ? (32'd0 - bus.src2) : bus.src2;

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. A fitting difference is always
    // below the divisor, so 32-bit wraparound subtraction is exact.
    logic [32:0] div_partial;
    logic        div_ge;
    logic [31:0] div_sub;
    assign div_partial = {div_rem, div_quot[31]};
    assign div_ge      = div_partial >= {1'b0, div_dsor};
    assign div_sub     = div_partial[31:0] - div_dsor;

    logic [31:0] fix_lo;
    logic [31:0] fix_hi;
    assign fix_lo = q_neg ? (32'd0 - div_quot) : div_quot;
    assign fix_hi = r_neg ? (32'd0 - div_rem) : div_rem;

    // Control FSM plus the architectural HI/LO registers and the done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= 5'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_mthi) begin
                        hi_q <= bus.src1;
                    end else if (sel_mtlo) begin
                        lo_q <= bus.src1;
                    end else if (sel_mult || sel_multu) begin
                        state <= ST_MUL;
                        cnt   <= MUL_CNT_INIT;
                    end else if (sel_div || sel_divu) begin
                        state <= ST_DIV;
                        cnt   <= 5'd31;
                    end
                end
                ST_MUL: begin
                    if (bus.cancel) begin
                        state <= ST_IDLE;
                    end else if (cnt == 5'd0) begin
                        {hi_q, lo_q} <= prod_q;
                        done_q       <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ST_DIV: begin
                    if (bus.cancel) begin
                        state <= ST_IDLE;
                    end else if (cnt == 5'd0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ST_FIX: begin
                    if (bus.cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture at acceptance and the per-edge divide iteration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod_q   <= 64'd0;
            div_rem  <= 32'd0;
            div_quot <= 32'd0;
            div_dsor <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
        end else if (sel_mult || sel_multu) begin
            prod_q <= mul_prod;
        end else if (sel_div || sel_divu) begin
            div_rem  <= 32'd0;
            div_quot <= abs_a;
            div_dsor <= abs_b;
            q_neg    <= sel_div & (bus.src1[31] ^ bus.src2[31]);
            r_neg    <= sel_div & bus.src1[31];
        end else if (state == ST_DIV && !bus.cancel) begin
            div_rem  <= div_ge ? div_sub : div_partial[31:0];
            div_quot <= {div_quot[30:0], div_ge};
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done_q;

`ifdef HILO_BYPASS_EN
    assign bus.hi_rdata = sel_mthi ? bus.src1 : hi_q;
    assign bus.lo_rdata = sel_mtlo ? bus.src1 : lo_q;
`else
    assign bus.hi_rdata = hi_q;
    assign bus.lo_rdata = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Testbench for hilo_muldiv_unit: directed scenarios plus randomized ops
// checked against an arithmetic reference model of HI/LO results and latency.
module tb_hilo_muldiv_unit;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    localparam logic [5:0] OP_MTHI  = 6'b100000;
    localparam logic [5:0] OP_MTLO  = 6'b010000;
    localparam logic [5:0] OP_MULT  = 6'b001000;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_DIV   = 6'b000010;
    localparam logic [5:0] OP_DIVU  = 6'b000001;

    logic clk = 1'b0;
    logic resetn = 1'b1;

    hilo_muldiv_unit_if bus();

    hilo_muldiv_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        {bus.op_mthi, bus.op_mtlo, bus.op_mult, bus.op_multu, bus.op_div, bus.op_divu} = ops;
        bus.src1 = a;
        bus.src2 = b;
    endtask

    task automatic clear_req();
        bus.op_valid = 1'b0;
        {bus.op_mthi, bus.op_mtlo, bus.op_mult, bus.op_multu, bus.op_div, bus.op_divu} = 6'b0;
    endtask

    // Index of the winning op: 0 mthi, 1 mtlo, 2 mult, 3 multu, 4 div, 5 divu.
    function automatic int winner(input logic [5:0] ops);
        for (int i = 5; i >= 0; i--) begin
            if (ops[i]) return 5 - i;
        end
        return -1;
    endfunction

    function automatic int expected_busy(input int w);
        if (w == 2 || w == 3) return MUL_LAT;
        if (w == 4 || w == 5) return DIV_LAT;
        return 0;
    endfunction

    // {HI, LO} from plain arithmetic; kind 0 mult, 1 multu, 2 div, 3 divu.
    function automatic logic [63:0] model_muldiv(input int kind, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'd0;
        case (kind)
            0: begin
                q = sa * sb;
                p = q;
            end
            1: p = {32'd0, a} * {32'd0, b};
            2: begin
                if (sb == 0) begin
                    r = sa;
                    q = (sa < 0) ? 64'sd1 : 64'sh00000000FFFFFFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
                p = {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else            p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic apply_model(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = winner(ops);
        if (w == 0)      exp_hi = a;
        else if (w == 1) exp_lo = a;
        else if (w >= 2) {exp_hi, exp_lo} = model_muldiv(w - 2, a, b);
    endtask

    // Issues one op, then reports how many cycles busy stayed high and the
    // done level in the first cycle afterwards (the cycle it returns in).
    task automatic run_op(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output logic done_now);
        applyStimulus(ops, a, b);
        step();
        clear_req();
        busy_cycles = 0;
        while (bus.busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            step();
        end
        done_now = bus.done;
    endtask

    task automatic test_reset();
        clear_req();
        bus.src1 = 32'd0;
        bus.src2 = 32'd0;
        bus.cancel = 1'b0;
        #1 resetn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.hi_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi got %h want 0", bus.hi_rdata); end
        checks++; if (bus.lo_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo got %h want 0", bus.lo_rdata); end
        step();
        resetn = 1'b1;
        step();
        exp_hi = 32'd0;
        exp_lo = 32'd0;
    endtask

    task automatic test_mult();
        logic [5:0]  t_ops [3] = '{OP_MULT, OP_MULTU, OP_MULT};
        logic [31:0] t_a   [3] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] t_b   [3] = '{32'h00000003, 32'h80000001, 32'h80000000};
        int bc;
        logic dn;
        for (int i = 0; i < 3; i++) begin
            run_op(t_ops[i], t_a[i], t_b[i], bc, dn);
            apply_model(t_ops[i], t_a[i], t_b[i]);
            checks++; if (bc != MUL_LAT) begin errors++; $display("[TB] FAIL mult%0d_busy got %0d want %0d", i, bc, MUL_LAT); end
            checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL mult%0d_done got %b want 1", i, dn); end
            checks++; if (bus.hi_rdata !== exp_hi) begin errors++; $display("[TB] FAIL mult%0d_hi got %h want %h", i, bus.hi_rdata, exp_hi); end
            checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL mult%0d_lo got %h want %h", i, bus.lo_rdata, exp_lo); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  t_ops [3];
        logic [31:0] t_a   [3];
        logic [31:0] t_b   [3];
        int bc;
        logic dn;
        t_ops = '{OP_MULTU, OP_MULT, OP_DIVU};
        t_a   = '{32'hFFFFFFFF, $urandom, $urandom};
        t_b   = '{32'hFFFFFFFF, $urandom, $urandom_range(1, 1000)};
        for (int i = 0; i < 3; i++) begin
            run_op(t_ops[i], t_a[i], t_b[i], bc, dn);
            apply_model(t_ops[i], t_a[i], t_b[i]);
            checks++; if (bc != expected_busy(winner(t_ops[i]))) begin errors++; $display("[TB] FAIL b2b%0d_busy got %0d want %0d", i, bc, expected_busy(winner(t_ops[i]))); end
            checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL b2b%0d_done got %b want 1", i, dn); end
            checks++; if (bus.hi_rdata !== exp_hi) begin errors++; $display("[TB] FAIL b2b%0d_hi got %h want %h", i, bus.hi_rdata, exp_hi); end
            checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL b2b%0d_lo got %h want %h", i, bus.lo_rdata, exp_lo); end
        end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL done_one_cycle got %b want 0", bus.done); end
    endtask

    task automatic test_div();
        logic [5:0]  t_ops [5] = '{OP_DIV, OP_DIVU, OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] t_a   [5] = '{32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] t_b   [5] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd0};
        int bc;
        logic dn;
        for (int i = 0; i < 5; i++) begin
            run_op(t_ops[i], t_a[i], t_b[i], bc, dn);
            apply_model(t_ops[i], t_a[i], t_b[i]);
            checks++; if (bc != DIV_LAT) begin errors++; $display("[TB] FAIL div%0d_busy got %0d want %0d", i, bc, DIV_LAT); end
            checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL div%0d_done got %b want 1", i, dn); end
            checks++; if (bus.hi_rdata !== exp_hi) begin errors++; $display("[TB] FAIL div%0d_hi got %h want %h", i, bus.hi_rdata, exp_hi); end
            checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL div%0d_lo got %h want %h", i, bus.lo_rdata, exp_lo); end
        end
    endtask

    task automatic test_cancel();
        int bc;
        logic dn;
        logic [31:0] a1, b1;
        // mthi: immediate write, no busy, no done
        run_op(OP_MTHI, 32'h12345678, 32'd0, bc, dn);
        apply_model(OP_MTHI, 32'h12345678, 32'd0);
        checks++; if (bc != 0) begin errors++; $display("[TB] FAIL mthi_busy got %0d want 0", bc); end
        checks++; if (dn !== 1'b0) begin errors++; $display("[TB] FAIL mthi_done got %b want 0", dn); end
        checks++; if (bus.hi_rdata !== exp_hi) begin errors++; $display("[TB] FAIL mthi_hi got %h want %h", bus.hi_rdata, exp_hi); end

        // div cancelled on busy cycle 10
        applyStimulus(OP_DIV, $urandom, $urandom);
        step();
        clear_req();
        for (int k = 1; k < 10; k++) step();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL cancel_pre_busy got %b want 1", bus.busy); end
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL cancel_done got %b want 0", bus.done); end
        checks++; if (bus.hi_rdata !== exp_hi) begin errors++; $display("[TB] FAIL cancel_hi got %h want %h", bus.hi_rdata, exp_hi); end
        checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL cancel_lo got %h want %h", bus.lo_rdata, exp_lo); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL cancel_late_done got %b want 0", bus.done); end

        // cancel coinciding with the multiply write edge suppresses the write
        applyStimulus(OP_MULT, 32'h00010001, 32'h00030003);
        step();
        clear_req();
        for (int k = 1; k < MUL_LAT; k++) step();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL cancel_wr_done got %b want 0", bus.done); end
        checks++; if (bus.hi_rdata !== exp_hi) begin errors++; $display("[TB] FAIL cancel_wr_hi got %h want %h", bus.hi_rdata, exp_hi); end
        checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL cancel_wr_lo got %h want %h", bus.lo_rdata, exp_lo); end

        // cancel in idle blocks acceptance, mtlo and mult alike
        applyStimulus(OP_MTLO, ~exp_lo, 32'd0);
        bus.cancel = 1'b1;
        step();
        applyStimulus(OP_MULT, 32'd5, 32'd5);
        step();
        bus.cancel = 1'b0;
        clear_req();
        checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL idle_cancel_lo got %h want %h", bus.lo_rdata, exp_lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_cancel_busy got %b want 0", bus.busy); end

        // a divide presented while busy is ignored
        a1 = $urandom;
        b1 = $urandom_range(1, 65535);
        applyStimulus(OP_DIVU, a1, b1);
        step();
        clear_req();
        bc = 0;
        while (bus.busy === 1'b1 && bc < 200) begin
            bc++;
            if (bc == 5) applyStimulus(OP_DIV, $urandom, $urandom);
            if (bc == 8) clear_req();
            step();
        end
        apply_model(OP_DIVU, a1, b1);
        checks++; if (bc != DIV_LAT) begin errors++; $display("[TB] FAIL ignore_busy got %0d want %0d", bc, DIV_LAT); end
        checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL ignore_lo got %h want %h", bus.lo_rdata, exp_lo); end
        checks++; if (bus.hi_rdata !== exp_hi) begin errors++; $display("[TB] FAIL ignore_hi got %h want %h", bus.hi_rdata, exp_hi); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_restart got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int bc;
        logic dn;
        run_op(OP_MTLO, 32'h55AA55AA, 32'd0, bc, dn);
        apply_model(OP_MTLO, 32'h55AA55AA, 32'd0);
        run_op(OP_MTHI, 32'hA5A5A5A5, 32'd0, bc, dn);
        apply_model(OP_MTHI, 32'hA5A5A5A5, 32'd0);
        applyStimulus(OP_DIV, $urandom, $urandom_range(1, 100));
        step();
        clear_req();
        for (int k = 1; k < 20; k++) step();
        resetn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done got %b want 0", bus.done); end
        checks++; if (bus.hi_rdata !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_hi got %h want 0", bus.hi_rdata); end
        checks++; if (bus.lo_rdata !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_lo got %h want 0", bus.lo_rdata); end
        resetn = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_bypass();
        run_op_mtlo_seed();
        applyStimulus(OP_MTLO, 32'hCAFEF00D, 32'd0);
        #1;
`ifdef HILO_BYPASS_EN
        checks++; if (bus.lo_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL bypass_same_cycle got %h want cafef00d", bus.lo_rdata); end
`else
        checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL nobypass_same_cycle got %h want %h", bus.lo_rdata, exp_lo); end
`endif
        step();
        clear_req();
        apply_model(OP_MTLO, 32'hCAFEF00D, 32'd0);
        checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL mtlo_next_cycle got %h want %h", bus.lo_rdata, exp_lo); end
    endtask

    task automatic run_op_mtlo_seed();
        int bc;
        logic dn;
        run_op(OP_MTLO, 32'h11111111, 32'd0, bc, dn);
        apply_model(OP_MTLO, 32'h11111111, 32'd0);
    endtask

    task automatic test_random();
        logic [5:0]  ops;
        logic [31:0] a, b;
        int bit_sel, w, bc;
        logic dn;
        for (int i = 0; i < 40; i++) begin
            bit_sel = $urandom_range(0, 5);
            ops = 6'(1 << bit_sel);
            if ($urandom_range(0, 3) == 0) ops = ops | (6'($urandom) & 6'((1 << bit_sel) - 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            w = winner(ops);
            run_op(ops, a, b, bc, dn);
            apply_model(ops, a, b);
            checks++; if (bc != expected_busy(w)) begin errors++; $display("[TB] FAIL rnd%0d_busy ops=%b got %0d want %0d", i, ops, bc, expected_busy(w)); end
            checks++; if (dn !== (w >= 2)) begin errors++; $display("[TB] FAIL rnd%0d_done ops=%b got %b want %b", i, ops, dn, (w >= 2)); end
            checks++; if (bus.hi_rdata !== exp_hi) begin errors++; $display("[TB] FAIL rnd%0d_hi ops=%b a=%h b=%h got %h want %h", i, ops, a, b, bus.hi_rdata, exp_hi); end
            checks++; if (bus.lo_rdata !== exp_lo) begin errors++; $display("[TB] FAIL rnd%0d_lo ops=%b a=%h b=%h got %h want %h", i, ops, a, b, bus.lo_rdata, exp_lo); end
        end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_cancel();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
